// File: rtl/pulse_transmitter_pkg.sv
// Shared types and symbol field layout for the pulse transmitter sequencer.
package pulse_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int SYMBOL_WIDTH = 13;
    localparam int LEVEL_BIT    = 12;
    localparam int PRESC_MSB    = 11;
    localparam int PRESC_LSB    = 8;
    localparam int DUR_MSB      = 7;
    localparam int DUR_LSB      = 0;
    localparam int SHIFT_WIDTH  = 24;

    // Scaled interval length; 255 << 15 still fits in 24 bits.
    function automatic logic [SHIFT_WIDTH-1:0] symbol_ticks(input logic [7:0] dur,
                                                            input logic [3:0] presc);
        return SHIFT_WIDTH'(dur) << presc;
    endfunction

endpackage

// File: rtl/pulse_transmitter_countdown_timer.sv
// Interval timer: while enabled, pulses once every (duration << prescaler) + 2 cycles.
module pulse_transmitter_countdown_timer
    import pulse_transmitter_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 15,
    parameter int TIMER_WIDTH     = 8,
    localparam int PSC_W = $clog2(PRESCALER_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PSC_W-1:0]       prescaler,
    input  logic [TIMER_WIDTH-1:0] duration,
    output logic                   pulse
);

    logic [SHIFT_WIDTH-1:0] cnt_q;
    logic [SHIFT_WIDTH-1:0] cnt_d;
    logic [SHIFT_WIDTH-1:0] reload;

    // Counting from ticks+1 down to zero spans ticks+2 enabled cycles.
    assign reload = (SHIFT_WIDTH'(duration) << prescaler) + SHIFT_WIDTH'(1);

    always_comb begin
        cnt_d = reload;
        if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - SHIFT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse = enable && (cnt_q == '0);

endmodule

// File: rtl/pulse_transmitter_symbol_table.sv
// Symbol table: register array with a synchronous write port and an asynchronous read by index.
module pulse_transmitter_symbol_table
    import pulse_transmitter_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_addr,
    input  logic [SYMBOL_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [SYMBOL_WIDTH-1:0] rd_data
);

    logic [SYMBOL_WIDTH-1:0] mem_q [DEPTH];
    logic [SYMBOL_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/pulse_transmitter_sequencer.sv
// Plays the programmed symbol table on tx_out with hardware-timed intervals.
// Optional repeat passes are enabled by defining PULSE_TRANSMITTER_LOOP_EN.
module pulse_transmitter_sequencer
    import pulse_transmitter_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 15,
    parameter int TIMER_WIDTH     = 8,
    parameter int DEPTH           = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PSC_W = $clog2(PRESCALER_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_addr,
    input  logic [SYMBOL_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]        sym_count,
`ifdef PULSE_TRANSMITTER_LOOP_EN
    input  logic [7:0]              loop_count,
`endif
    input  logic                    idle_level,
    input  logic                    start,
    input  logic                    stop,
    output logic                    tx_out,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        sym_index
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic                    tx_out_q, tx_out_d;
    logic                    done_q, done_d;
    logic [PSC_W-1:0]        presc_q, presc_d;
    logic [TIMER_WIDTH-1:0]  dur_q, dur_d;
`ifdef PULSE_TRANSMITTER_LOOP_EN
    logic [7:0]              loop_q, loop_d;
`endif

    logic [SYMBOL_WIDTH-1:0] rd_data;
    logic                    rd_level;
    logic [PSC_W-1:0]        rd_presc;
    logic [TIMER_WIDTH-1:0]  rd_dur;
    logic                    timer_en;
    logic                    timer_pulse;
    logic [PSC_W-1:0]        timer_presc;
    logic [TIMER_WIDTH-1:0]  timer_dur;

    pulse_transmitter_symbol_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    assign rd_level = rd_data[LEVEL_BIT];
    assign rd_presc = rd_data[PRESC_MSB:PRESC_LSB];
    assign rd_dur   = rd_data[DUR_MSB:DUR_LSB];

    pulse_transmitter_countdown_timer #(
        .PRESCALER_WIDTH (PRESCALER_WIDTH),
        .TIMER_WIDTH     (TIMER_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst_n     (~sys_rst),
        .enable    (timer_en),
        .prescaler (timer_presc),
        .duration  (timer_dur),
        .pulse     (timer_pulse)
    );

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            tx_out_q <= 1'b0;
            done_q   <= 1'b0;
            presc_q  <= '0;
            dur_q    <= '0;
`ifdef PULSE_TRANSMITTER_LOOP_EN
            loop_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            tx_out_q <= tx_out_d;
            done_q   <= done_d;
            presc_q  <= presc_d;
            dur_q    <= dur_d;
`ifdef PULSE_TRANSMITTER_LOOP_EN
            loop_q   <= loop_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        tx_out_d = tx_out_q;
        done_d   = 1'b0;
        presc_d  = presc_q;
        dur_d    = dur_q;
`ifdef PULSE_TRANSMITTER_LOOP_EN
        loop_d   = loop_q;
`endif
        case (state_q)
            IDLE: begin
                tx_out_d = idle_level;
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    count_d = sym_count;
`ifdef PULSE_TRANSMITTER_LOOP_EN
                    loop_d  = loop_count;
`endif
                end
            end
            LOAD: begin
                tx_out_d = rd_level;
                presc_d  = rd_presc;
                dur_d    = rd_dur;
                state_d  = RUN;
            end
            RUN: begin
                if (timer_pulse) begin
                    if (idx_q != count_q) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
`ifdef PULSE_TRANSMITTER_LOOP_EN
                    end else if (loop_q != '0) begin
                        loop_d  = loop_q - 8'd1;
                        idx_d   = '0;
                        state_d = LOAD;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Level still holds this cycle; done_q pulses on the following one.
                tx_out_d = idle_level;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides any step taken this cycle, keeping the current index.
        if (stop && ((state_q == LOAD) || (state_q == RUN))) begin
            state_d  = IDLE;
            idx_d    = idx_q;
            tx_out_d = idle_level;
        end
    end

    // LOAD feeds the table straight to the timer so it is stable before enable rises.
    always_comb begin
        busy        = (state_q != IDLE);
        timer_en    = (state_q == RUN);
        timer_presc = (state_q == LOAD) ? rd_presc : presc_q;
        timer_dur   = (state_q == LOAD) ? rd_dur : dur_q;
    end

    assign tx_out    = tx_out_q;
    assign done      = done_q;
    assign sym_index = idx_q;

endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Randomized scoreboard bench for pulse_transmitter_sequencer; expected per-cycle outputs are queued at start.
module tb_pulse_transmitter_sequencer;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [12:0] wr_data;
    logic [2:0]  sym_count;
    logic [7:0]  loop_count;
    logic        idle_level;
    logic        start;
    logic        stop;
    logic        tx_out;
    logic        busy;
    logic        done;
    logic [2:0]  sym_index;

    int errors = 0;
    int checks = 0;

    // Expected per-cycle {busy, done, tx_out, sym_index}
    logic [5:0]  exp_q[$];
    logic [5:0]  mon_e;
    logic [12:0] tbl [8];
    logic        idle_d1 = 1'b0;
    logic [2:0]  last_idx = 3'd0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    pulse_transmitter_sequencer dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sym_count  (sym_count),
`ifdef PULSE_TRANSMITTER_LOOP_EN
        .loop_count (loop_count),
`endif
        .idle_level (idle_level),
        .start      (start),
        .stop       (stop),
        .tx_out     (tx_out),
        .busy       (busy),
        .done       (done),
        .sym_index  (sym_index)
    );

    // The pin is registered, so the idle level shows one cycle after it is applied.
    always @(posedge clk) idle_d1 <= idle_level;

    always @(negedge clk) begin
        if (!sys_rst && mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                last_idx = mon_e[2:0];
                checks++;
                if ({busy, done, tx_out, sym_index} !== mon_e) begin
                    errors++;
                    $display("FAIL seq_cycle t=%0t got busy=%b done=%b tx=%b idx=%0d want busy=%b done=%b tx=%b idx=%0d",
                             $time, busy, done, tx_out, sym_index, mon_e[5], mon_e[4], mon_e[3], mon_e[2:0]);
                end
            end else begin
                checks++;
                if ({busy, done, tx_out} !== {2'b00, idle_d1}) begin
                    errors++;
                    $display("FAIL idle_state t=%0t got busy=%b done=%b tx=%b want busy=0 done=0 tx=%b",
                             $time, busy, done, tx_out, idle_d1);
                end
            end
        end
    end

    // Reference: each symbol shows its level for (dur<<presc)+3 cycles, the index
    // advancing on the symbol's last cycle, followed by one done cycle at idle.
    task automatic push_seq(input int cnt, input int loops, input logic idle);
        int len;
        int nxt;
        exp_q.push_back({1'b1, 1'b0, idle, 3'd0});
        for (int p = 0; p <= loops; p++) begin
            for (int k = 0; k <= cnt; k++) begin
                len = (int'(tbl[k][7:0]) << tbl[k][11:8]) + 3;
                nxt = (k < cnt) ? k + 1 : ((p < loops) ? 0 : k);
                for (int c = 0; c < len; c++) begin
                    exp_q.push_back({1'b1, 1'b0, tbl[k][12], (c == len - 1) ? 3'(nxt) : 3'(k)});
                end
            end
        end
        exp_q.push_back({1'b0, 1'b1, idle, 3'(cnt)});
    endtask

    task automatic write_dut(input int addr, input logic [12:0] data);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic set_entry(input int addr, input logic lvl, input int presc, input int dur);
        tbl[addr] = {lvl, 4'(presc), 8'(dur)};
        write_dut(addr, tbl[addr]);
    endtask

    task automatic do_start(input int cnt, input int loops);
        int eff_loops;
`ifdef PULSE_TRANSMITTER_LOOP_EN
        eff_loops = loops;
`else
        eff_loops = 0;
`endif
        @(posedge clk); #1;
        sym_count = 3'(cnt); loop_count = 8'(loops); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_seq(cnt, eff_loops, idle_level);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0 after %0d cycles", exp_q.size(), max_cycles);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic set_idle(input logic lvl);
        @(posedge clk); #1;
        idle_level = lvl;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int cnt;
        int loops;
        sys_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sym_count = '0; loop_count = '0; idle_level = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_out, busy, done, sym_index} !== 6'b0) begin
            errors++;
            $display("FAIL reset_values got tx=%b busy=%b done=%b idx=%0d want all 0", tx_out, busy, done, sym_index);
        end
        @(posedge clk); #1;
        sys_rst = 1'b0;
        mon_en = 1'b1;

        // Single 8-cycle symbol
        set_entry(0, 1'b1, 0, 5);
        do_start(0, 0);
        wait_drain(200);

        // Prescaled symbol followed by a zero-duration symbol
        set_entry(0, 1'b1, 2, 3);
        set_entry(1, 1'b0, 0, 0);
        do_start(1, 0);
        wait_drain(200);

        // Abort mid-RUN, then replay from entry 0
        set_entry(0, 1'b1, 0, 97);
        do_start(0, 0);
        repeat (4) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        exp_q.delete();
        exp_q.push_back({1'b0, 1'b0, idle_level, last_idx});
        wait_drain(20);
        do_start(0, 0);
        wait_drain(300);

        // Stop while idle has no effect
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        repeat (3) @(posedge clk);

        // Rewrite entry 1 while entry 0 is still playing
        set_entry(0, 1'b1, 0, 20);
        set_entry(1, 1'b0, 0, 10);
        tbl[1] = {1'b0, 4'd0, 8'd2};
        do_start(1, 0);
        repeat (5) @(posedge clk);
        write_dut(1, tbl[1]);
        wait_drain(200);

        // Repeat passes (single pass when the loop feature is absent)
        set_entry(0, 1'b1, 0, 1);
        set_entry(1, 1'b0, 0, 1);
        do_start(1, 2);
        wait_drain(200);

        // Start ignored while busy, then reset mid-sequence
        set_idle(1'b1);
        set_entry(0, 1'b0, 0, 30);
        do_start(0, 0);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b1;
        @(posedge clk); #1;
        sys_rst = 1'b0;
        exp_q.delete();
        exp_q.push_back({1'b0, 1'b0, 1'b0, 3'd0});
        wait_drain(20);

        // Randomized sequences
        for (int it = 0; it < 25; it++) begin
            cnt = $urandom_range(0, 7);
            loops = $urandom_range(0, 2);
            for (int k = 0; k <= cnt; k++) begin
                set_entry(k, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 6));
            end
            set_idle(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_start(cnt, loops);
            wait_drain(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_transmitter_sequencer.md
# pulse_transmitter_sequencer

Plays a programmed list of pulse symbols on a single transmit pin. The sequencer holds an 8-entry symbol table, steps through it, and drives the level of each symbol for a hardware-timed interval. Interval timing comes from an instance of `pulse_transmitter_countdown_timer`. The block sits between the peripheral register interface (table writes, start/stop) and the output pin.

## Interface
- `PRESCALER_WIDTH`, default 15: largest left-shift applied to a duration; the prescaler field is $clog2(PRESCALER_WIDTH+1) = 4 bits.
- `TIMER_WIDTH`, default 8: width of the duration field.
- `DEPTH`, default 8: number of symbol table entries; index width is $clog2(DEPTH) = 3.
- `clk`, input, 1: single clock.
- `sys_rst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: write one symbol table entry this cycle.
- `wr_addr`, input, 3: entry index to write.
- `wr_data`, input, 13: symbol, packed as {level[12], prescaler[11:8], duration[7:0]}.
- `sym_count`, input, 3: number of symbols to play minus 1 (0 plays 1 symbol, 7 plays 8).
- `loop_count`, input, 8: extra passes over the table. Present only with the macro.
- `idle_level`, input, 1: level driven on `tx_out` when not playing.
- `start`, input, 1: one-cycle request to begin a sequence.
- `stop`, input, 1: abort the running sequence.
- `tx_out`, output, 1: pin level. Registered.
- `busy`, output, 1: high while a sequence is in progress.
- `done`, output, 1: one-cycle pulse when a sequence completes normally.
- `sym_index`, output, 3: index of the current symbol.

## Operation
- The symbol table is a register array. It is written whenever `wr_en` is high, including while `busy`. A write to an entry takes effect at that entry's next LOAD.
- Sequencer states:
  - IDLE: `tx_out`=`idle_level`, timer enable 0. On `start`: index←0, latch `sym_count` and `loop_count`, go to LOAD.
  - LOAD (one cycle): present table[index].prescaler and .duration to the timer with enable 0. Set `tx_out`←table[index].level. Go to RUN.
  - RUN: timer enable 1, prescaler and duration held. On timer pulse:
    - if index≠sym_count: index+1, go to LOAD;
    - else if loops remain: decrement the loop counter, index←0, go to LOAD;
    - else go to DONE.
  - DONE (one cycle): `done`=1, `tx_out`=`idle_level`, go to IDLE.
- `start` while `busy` is ignored.
- `stop` in LOAD or RUN forces IDLE next cycle: `tx_out`=`idle_level`, no `done`, timer enable 0. `stop` in IDLE or DONE has no effect.
- `stop` and `start` in the same IDLE cycle: `start` wins. In the same busy cycle: `stop` wins.
- `busy` is 1 in LOAD, RUN and DONE.
- The timer's active-low reset is driven from `~sys_rst`.

## Timing
- Reset values: state IDLE, `tx_out`=0, `busy`=0, `done`=0, `sym_index`=0, loop counter 0. Symbol table contents are not reset.
- `start` at cycle T: LOAD in T+1, new level on `tx_out` from T+2.
- Each symbol occupies exactly (duration<<prescaler)+3 cycles on `tx_out`: one LOAD cycle plus the timer's (duration<<prescaler)+2.
  - Duration 0 gives a 3-cycle symbol.
  - Symbols are back to back, with no idle gap between them.
- The timer's prescaler and duration inputs must be stable one cycle before enable rises. The LOAD cycle guarantees this.
- The shift is computed to 24 bits. No overflow is possible at the maximum values (duration 255, prescaler 15).
- `done` asserts in the cycle after the last symbol's final cycle.
- `sym_index` updates on entry to LOAD.
- `sys_rst` mid-sequence returns all state to reset values the next cycle.

## Configuration
- `PULSE_TRANSMITTER_LOOP_EN` defined: the `loop_count` port exists and a sequence plays loop_count+1 times. loop_count=255 gives 256 passes.
- Not defined: no `loop_count` port and no loop counter; each sequence plays exactly once.

## Structure
- Shared package `pulse_transmitter_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - the symbol field bit positions (LEVEL_BIT=12, PRESC_MSB/LSB=11/8, DUR_MSB/LSB=7/0);
  - SYMBOL_WIDTH=13.
- One sub-module, `pulse_transmitter_symbol_table`: synchronous write port, asynchronous read by index.
- `pulse_transmitter_countdown_timer` is instantiated directly.

## Test plan
- Single symbol: sym_count=0, entry0={1,0,5}, idle_level=0, start → `tx_out`=1 for exactly 8 cycles, then 0; `done` pulses once.
- Prescaled sequence: entry0={1,2,3}, entry1={0,0,0}, sym_count=1 → high 15 cycles, then low 3 cycles, then idle; `sym_index` reads 0, then 1.
- Stop mid-RUN: assert `stop` 4 cycles into a 100-cycle symbol → `tx_out`=`idle_level` next cycle, `busy`=0, no `done`; a following `start` replays from entry 0.
- Write while busy: rewrite entry1 duration from 10 to 2 while entry0 is playing → entry1 lasts 5 cycles.
- Loop (macro on): loop_count=2, two symbols of 4 cycles each → 24 cycles of pattern, then a single `done`. Macro off: 8 cycles.
- Reset mid-sequence and start-while-busy: `sys_rst` pulse → `tx_out`=0, `busy`=0 next cycle; `start` during RUN → no restart, `sym_index` unchanged.
